// File: rtl/patch_pkg.sv
// Shared definitions for the patch fetch unit: FSM state encoding and
// default geometry of the patch memory.
package patch_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 16;
  localparam int DEFAULT_PATCH_WIDTH = 320;
  localparam int DEFAULT_CNT_WIDTH   = 16;

  // IDLE: waiting for a request; WAIT: memory read in flight;
  // OUT: patch presented to the consumer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } patch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Increment on request, hold once every bit is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + ONE;
    end
  end

endmodule

// File: rtl/patch_fetch_unit.sv
// Patch fetch unit: looks up a one-entry patch buffer by word index,
// fetches from the patch memory on a miss, and hands the patch to the
// consumer with a valid/ready handshake.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a patch transfers on a rising edge where
// patch_valid_o and patch_ready_i are both 1. Neither side may make its
// valid depend combinationally on the other side's ready.
module patch_fetch_unit
  import patch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int PATCH_WIDTH = DEFAULT_PATCH_WIDTH,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  output logic                   req_ready_o,
  output logic [ADDR_WIDTH-1:0]  patch_addr_o,
  input  logic [PATCH_WIDTH-1:0] patch_i,
  output logic                   patch_valid_o,
  output logic [PATCH_WIDTH-1:0] patch_data_o,
  output logic [ADDR_WIDTH-3:0]  patch_tag_o,
  input  logic                   patch_ready_i,
  input  logic                   flush_i,
  input  logic                   invalidate_i,
  output logic [CNT_WIDTH-1:0]   hit_cnt_o,
  output logic [CNT_WIDTH-1:0]   miss_cnt_o,
  output logic [1:0]             dbg_state_o,
  output logic                   dbg_buf_valid_o,
  output logic [ADDR_WIDTH-3:0]  dbg_buf_tag_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  patch_state_e           state_q, state_d;
  logic [IDX_W-1:0]       req_idx;
  logic [IDX_W-1:0]       buf_tag_q;
  logic                   buf_valid_q;
  logic [PATCH_WIDTH-1:0] buf_data_q;
  logic [ADDR_WIDTH-1:0]  patch_addr_q;
  logic                   ready;
  logic                   accept;
  logic                   hit;
  logic                   capture;
  logic                   unused_addr_lsb;

  // Byte offset within a word does not select a different patch.
  assign req_idx         = req_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign hit             = buf_valid_q && (req_idx == buf_tag_q);

  // Next state, request acceptance and capture strobe.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_WAIT: begin
        capture = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        ready = patch_ready_i;
        if (patch_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush kills the in-flight read and blocks new requests this cycle.
    if (flush_i) begin
      ready   = 1'b0;
      capture = 1'b0;
      state_d = ST_IDLE;
    end
    accept = req_valid_i && ready;
    if (accept) begin
      state_d = hit ? ST_OUT : ST_WAIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory address is only loaded on a miss, so it is stable through WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      patch_addr_q <= '0;
    end else if (accept && !hit) begin
      patch_addr_q <= {req_idx, 2'b00};
    end
  end

  // Patch buffer: a capture beats a simultaneous invalidate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_data_q  <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
    end else if (capture) begin
      buf_data_q  <= patch_i;
      buf_tag_q   <= patch_addr_q[ADDR_WIDTH-1:2];
      buf_valid_q <= 1'b1;
    end else if (invalidate_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (accept && hit),
    .cnt_o  (hit_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (accept && !hit),
    .cnt_o  (miss_cnt_o)
  );

  assign req_ready_o     = ready;
  assign patch_addr_o    = patch_addr_q;
  assign patch_valid_o   = (state_q == ST_OUT);
  assign patch_data_o    = buf_data_q;
  assign patch_tag_o     = buf_tag_q;
  assign dbg_state_o     = state_q;
  assign dbg_buf_valid_o = buf_valid_q;
  assign dbg_buf_tag_o   = buf_tag_q;

endmodule

// File: tb/tb_patch_fetch_unit.sv
// Directed + randomized bench for patch_fetch_unit with a transaction-level
// reference model of the patch buffer and statistics counters.
module tb_patch_fetch_unit;
  import patch_pkg::*;

  localparam int AW  = 16;
  localparam int PW  = 320;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic [AW-1:0] patch_addr;
  logic [PW-1:0] patch_in = '0;
  logic          patch_valid;
  logic [PW-1:0] patch_data;
  logic [AW-3:0] patch_tag;
  logic          patch_ready = 1'b0;
  logic          flush = 1'b0;
  logic          invalidate = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [1:0]    dbg_state;
  logic          dbg_buf_valid;
  logic [AW-3:0] dbg_buf_tag;

  patch_fetch_unit #(.ADDR_WIDTH(AW), .PATCH_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_ready_o     (req_ready),
    .patch_addr_o    (patch_addr),
    .patch_i         (patch_in),
    .patch_valid_o   (patch_valid),
    .patch_data_o    (patch_data),
    .patch_tag_o     (patch_tag),
    .patch_ready_i   (patch_ready),
    .flush_i         (flush),
    .invalidate_i    (invalidate),
    .hit_cnt_o       (hit_cnt),
    .miss_cnt_o      (miss_cnt),
    .dbg_state_o     (dbg_state),
    .dbg_buf_valid_o (dbg_buf_valid),
    .dbg_buf_tag_o   (dbg_buf_tag)
  );

  // ---------------- patch memory ----------------
  function automatic logic [PW-1:0] mem_word(input logic [AW-3:0] idx);
    logic [PW-1:0] w;
    for (int i = 0; i < PW / 32; i++) begin
      w[i*32 +: 32] = (32'(idx) * 32'h9E37_79B1) ^ (32'(i) << 24) ^ 32'h5A5A_0000;
    end
    return w;
  endfunction

  // Read data follows the registered address on the falling edge.
  always @(negedge clk) patch_in <= mem_word(patch_addr[AW-1:2]);

  // ---------------- reference model ----------------
  bit            m_valid;
  logic [AW-3:0] m_tag;
  logic [AW-1:0] m_addr;
  int            m_hit, m_miss;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_tag   = '0;
    m_addr  = '0;
    m_hit   = 0;
    m_miss  = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hit_cnt"}, PW'(hit_cnt), PW'(m_hit));
    chk({tag, "_miss_cnt"}, PW'(miss_cnt), PW'(m_miss));
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request (from IDLE or back-to-back from OUT) and check it lands in OUT.
  task automatic request(input logic [AW-1:0] addr, input bit inv_cap);
    logic [AW-3:0] idx;
    bit            is_hit;
    idx    = addr[AW-1:2];
    is_hit = m_valid && (idx == m_tag);
    req_valid   = 1'b1;
    req_addr    = addr;
    patch_ready = 1'b1;
    #1;
    chk("req_ready", PW'(req_ready), PW'(1));
    cyc();
    req_valid   = 1'b0;
    patch_ready = 1'b0;
    req_addr    = 16'($urandom);
    if (is_hit) begin
      m_hit = sat(m_hit);
    end else begin
      m_miss = sat(m_miss);
      m_addr = {idx, 2'b00};
      chk("miss_not_yet_valid", PW'(patch_valid), PW'(0));
      chk("miss_patch_addr", PW'(patch_addr), PW'(m_addr));
      if (inv_cap) invalidate = 1'b1;
      cyc();
      invalidate = 1'b0;
      m_valid = 1'b1;
      m_tag   = idx;
    end
    chk("out_valid", PW'(patch_valid), PW'(1));
    chk("out_data", patch_data, mem_word(idx));
    chk("out_tag", PW'(patch_tag), PW'(idx));
    chk("out_patch_addr", PW'(patch_addr), PW'(m_addr));
    chk("out_buf_valid", PW'(dbg_buf_valid), PW'(1));
    chk_counters("out");
  endtask

  // Consumer stalls in OUT: outputs must not move.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk("hold_valid", PW'(patch_valid), PW'(1));
      chk("hold_data", patch_data, mem_word(m_tag));
      chk("hold_tag", PW'(patch_tag), PW'(m_tag));
      chk("hold_req_ready", PW'(req_ready), PW'(0));
    end
  endtask

  // Consumer takes the patch with no new request behind it.
  task automatic release_patch();
    patch_ready = 1'b1;
    #1;
    chk("release_req_ready", PW'(req_ready), PW'(1));
    cyc();
    patch_ready = 1'b0;
    chk("release_valid", PW'(patch_valid), PW'(0));
    chk("release_state", PW'(dbg_state), PW'(ST_IDLE));
  endtask

  task automatic inval();
    invalidate = 1'b1;
    cyc();
    invalidate = 1'b0;
    m_valid = 1'b0;
    chk("inval_buf_valid", PW'(dbg_buf_valid), PW'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, PW'(dbg_state), PW'(ST_IDLE));
    chk({tag, "_valid"}, PW'(patch_valid), PW'(0));
    chk({tag, "_addr"}, PW'(patch_addr), PW'(0));
    chk({tag, "_data"}, patch_data, PW'(0));
    chk({tag, "_buf_valid"}, PW'(dbg_buf_valid), PW'(0));
    chk({tag, "_buf_tag"}, PW'(dbg_buf_tag), PW'(0));
    chk({tag, "_hit_cnt"}, PW'(hit_cnt), PW'(0));
    chk({tag, "_miss_cnt"}, PW'(miss_cnt), PW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit in_out;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    cyc();

    // First miss and a same-word hit back-to-back, then a stall.
    request(16'h0040, 1'b0);
    request(16'h0042, 1'b0);
    chk("hit_tag_0x10", PW'(patch_tag), PW'(16'h0010));
    chk("hit_addr_unchanged", PW'(patch_addr), PW'(16'h0040));
    hold(5);
    release_patch();

    // Flush during WAIT aborts the capture but keeps the old buffer.
    req_valid = 1'b1;
    req_addr  = 16'h0080;
    cyc();
    req_valid = 1'b0;
    m_miss = sat(m_miss);
    m_addr = 16'h0080;
    chk("flush_wait_state", PW'(dbg_state), PW'(ST_WAIT));
    flush = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush_req_ready", PW'(req_ready), PW'(0));
    cyc();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_state", PW'(dbg_state), PW'(ST_IDLE));
    chk("flush_valid", PW'(patch_valid), PW'(0));
    chk("flush_buf_tag", PW'(dbg_buf_tag), PW'(16'h0010));
    chk("flush_buf_valid", PW'(dbg_buf_valid), PW'(1));
    chk_counters("flush");
    cyc();
    chk("flush_no_late_valid", PW'(patch_valid), PW'(0));
    request(16'h0040, 1'b0);
    release_patch();

    // Invalidate forces a miss; invalidate at the capture edge loses.
    inval();
    request(16'h0040, 1'b0);
    release_patch();
    request(16'h00C0, 1'b1);
    chk("inv_cap_buf_tag", PW'(dbg_buf_tag), PW'(16'h0030));
    release_patch();

    // Randomized mix of hits, misses, stalls, back-to-back and invalidates.
    in_out = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) inval();
      a = 16'h0200 + 16'($urandom_range(0, 4) << 2) + 16'($urandom_range(0, 3));
      request(a, 1'($urandom_range(0, 5) == 0));
      hold($urandom_range(0, 2));
      in_out = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        release_patch();
        in_out = 1'b0;
      end
    end
    if (in_out) release_patch();

    // Reset in the middle of WAIT discards the transaction.
    req_valid = 1'b1;
    req_addr  = 16'h0140;
    cyc();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_state("mid_reset");
    cyc();
    rst_n = 1'b1;
    cyc();
    request(16'h0140, 1'b0);
    chk("post_reset_miss", PW'(miss_cnt), PW'(1));
    release_patch();

    // Flush in OUT drops the patch and blocks the pending request.
    request(16'h0141, 1'b0);
    flush = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush_out_req_ready", PW'(req_ready), PW'(0));
    cyc();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_out_state", PW'(dbg_state), PW'(ST_IDLE));
    chk("flush_out_valid", PW'(patch_valid), PW'(0));
    chk_counters("flush_out");

    // Twenty distinct misses saturate the 4-bit miss counter.
    for (int i = 0; i < 20; i++) begin
      request(16'h1000 + 16'(i * 4), 1'b0);
      release_patch();
    end
    chk("miss_sat", PW'(miss_cnt), PW'(4'hF));

    // Back-to-back hits deliver one patch per cycle.
    request(16'h2000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      request(16'h2000 + 16'($urandom_range(0, 3)), 1'b0);
    end
    release_patch();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
